// File: rtl/clk_div_1s.sv
// clk_div_1s: divides clk_100M down to a 50 % duty square wave clk_1s.
// HALF input cycles per output half-period; downstream samples clk_1s in
// the clk_100M domain.
// Optional feature macro: CLK_DIV_TICK_EN adds tick_1s, a one-cycle pulse
// asserted for the cycle after each clk_1s rising edge.
`timescale 1ns/1ps
module clk_div_1s #(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000,
  parameter int unsigned OUT_FREQ_HZ = 1
) (
  input  logic clk_100M,
  input  logic rst,
`ifdef CLK_DIV_TICK_EN
  output logic tick_1s,
`endif
  output logic clk_1s
);

  localparam int unsigned HALF_RAW = CLK_FREQ_HZ / (2 * OUT_FREQ_HZ);
  localparam int unsigned HALF     = (HALF_RAW < 1) ? 1 : HALF_RAW;
  localparam int unsigned HALF_LOG = $clog2(HALF);
  localparam int unsigned CW       = (HALF_LOG < 1) ? 1 : HALF_LOG;
  localparam logic [CW-1:0] CNT_LAST = CW'(HALF - 1);

  // Register initialisers give defined power-up values before any reset edge.
  logic [CW-1:0] cnt_q = '0;
  logic [CW-1:0] cnt_d;
  logic          clk_1s_q = 1'b0;
  logic          clk_1s_d;

  // Next-state: wrap only through the compare, never through overflow.
  always_comb begin
    cnt_d    = cnt_q;
    clk_1s_d = clk_1s_q;
    if (rst) begin
      cnt_d    = '0;
      clk_1s_d = 1'b0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d    = '0;
      clk_1s_d = ~clk_1s_q;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // State registers; reset is folded into the next-state logic.
  always_ff @(posedge clk_100M) begin
    cnt_q    <= cnt_d;
    clk_1s_q <= clk_1s_d;
  end

  assign clk_1s = clk_1s_q;

`ifdef CLK_DIV_TICK_EN
  logic tick_q = 1'b0;
  logic tick_d;

  // Pulse on the same edge that drives clk_1s from 0 to 1.
  always_comb begin
    tick_d = 1'b0;
    if (!rst && (cnt_q == CNT_LAST) && !clk_1s_q) begin
      tick_d = 1'b1;
    end
  end

  // Tick register.
  always_ff @(posedge clk_100M) begin
    tick_q <= tick_d;
  end

  assign tick_1s = tick_q;
`endif

endmodule

// File: tb/tb_clk_div_1s.sv
// Bench for clk_div_1s: HALF=5 and HALF=1 instances, scoreboard checking.
`timescale 1ns/1ps
module tb_clk_div_1s;

  typedef struct packed {
    logic exp5;
    logic exp1;
    logic tick;
    logic win;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clk5, clk1;
  logic tick5, tick1;

  int checks = 0;
  int failures = 0;
  exp_t q[$];
  bit drv_done = 1'b0;
  int rises = 0, falls = 0, ticks = 0;

  always #5 clk = ~clk;

  clk_div_1s #(.CLK_FREQ_HZ(10), .OUT_FREQ_HZ(1)) dut5 (
    .clk_100M(clk),
    .rst(rst),
`ifdef CLK_DIV_TICK_EN
    .tick_1s(tick5),
`endif
    .clk_1s(clk5)
  );

  clk_div_1s #(.CLK_FREQ_HZ(2), .OUT_FREQ_HZ(1)) dut1 (
    .clk_100M(clk),
    .rst(rst),
`ifdef CLK_DIV_TICK_EN
    .tick_1s(tick1),
`endif
    .clk_1s(clk1)
  );

`ifndef CLK_DIV_TICK_EN
  assign tick5 = 1'b0;
  assign tick1 = 1'b0;
`endif

  // Reference: edges since reset release decide the phase directly.
  int  e = 0;
  logic prev5 = 1'b0;

  task automatic step(input logic r, input logic w);
    exp_t it;
    @(negedge clk);
    rst = r;
    if (r) begin
      e = 0;
      it.exp5 = 1'b0;
      it.exp1 = 1'b0;
      it.tick = 1'b0;
    end else begin
      e = e + 1;
      it.exp5 = ((e / 5) % 2) == 1;
      it.exp1 = (e % 2) == 1;
      it.tick = it.exp5 && !prev5;
    end
    prev5 = it.exp5;
    it.win = w;
    q.push_back(it);
  endtask

  task automatic seg(input logic r, input int n, input logic w);
    for (int i = 0; i < n; i++) step(r, w);
  endtask

  task automatic check(input string name, input logic act, input logic req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, req);
    end
  endtask

  task automatic check_int(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor: one expected entry per clock edge, compared after the edge.
  initial begin : monitor
    exp_t it;
    logic last5;
    last5 = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        it = q.pop_front();
        check("clk_1s_half5", clk5, it.exp5);
        check("clk_1s_half1", clk1, it.exp1);
`ifdef CLK_DIV_TICK_EN
        check("tick_1s_half5", tick5, it.tick);
        if (it.win && tick5) ticks++;
`endif
        if (it.win && clk5 && !last5) rises++;
        if (it.win && !clk5 && last5) falls++;
        last5 = clk5;
      end
    end
  end

  // Directed stimulus: reset, mid-run reset while high, long run.
  initial begin : driver
    #1;
    check("powerup_clk_1s_half5", clk5, 1'b0);
    check("powerup_clk_1s_half1", clk1, 1'b0);
`ifdef CLK_DIV_TICK_EN
    check("powerup_tick_1s", tick5, 1'b0);
`endif
    seg(1'b1, 3, 1'b0);
    seg(1'b0, 18, 1'b0);   // ends with clk_1s=1, cnt=3
    seg(1'b1, 1, 1'b0);
    seg(1'b0, 12, 1'b0);
    seg(1'b1, 2, 1'b0);
    seg(1'b0, 1000, 1'b1);
    seg(1'b1, 1, 1'b0);
    seg(1'b0, 7, 1'b0);
    drv_done = 1'b1;
  end

  // End of run: drain the scoreboard within a bounded time.
  initial begin : finisher
    int guard;
    guard = 0;
    while (!drv_done && guard < 5000) begin
      @(posedge clk);
      guard++;
    end
    repeat (3) @(posedge clk);
    #2;
    check_int("driver_done", int'(drv_done), 1);
    check_int("queue_drained", q.size(), 0);
    check_int("long_run_rises", rises, 100);
    check_int("long_run_falls", falls, 100);
`ifdef CLK_DIV_TICK_EN
    check_int("long_run_ticks", ticks, 100);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
